// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  typedef logic port_idx_t;

  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int CNT_W               = 4;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of one SRAM arbiter port: request, qualifiers and completion.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [1:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, be, addr, wdata, input rdata, ack);
  modport slave  (input req, we, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not served last.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_idx_t last_grant,
  output logic      grant_valid,
  output port_idx_t grant_idx
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_idx = ~last_grant;
    end else begin
      grant_idx = req1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between the datapath (port 0) and the loader (port 1),
// producing registered active-low strobes with a fixed number of access wait states.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_arbiter_if.slave     port0,
  sram_arbiter_if.slave     port1,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              OE,
  output logic              WE,
  output logic              UB,
  output logic              LB,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              drive_en,
  input  logic [DATA_W-1:0] sram_rdata
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("sram_arbiter: WAIT_CYCLES must be within 1..15");
  end

  state_t            state_q, state_d;
  port_idx_t         last_grant_q, last_grant_d;
  port_idx_t         lat_idx_q, lat_idx_d;
  logic              lat_we_q, lat_we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ce_q, ce_d, oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d;
  logic              drive_en_q, drive_en_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]        sel_be;
  logic              grant_valid;
  port_idx_t         grant_idx;

  rr_arb2 u_arb (
    .req0        (port0.req),
    .req1        (port1.req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Strobes are computed one state ahead so every pin comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_idx_d    = lat_idx_q;
    lat_we_d     = lat_we_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ce_d         = ce_q;
    oe_d         = oe_q;
    we_d         = we_q;
    ub_d         = ub_q;
    lb_d         = lb_q;
    drive_en_d   = drive_en_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    sel_be       = grant_idx ? port1.be : port0.be;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d      = ST_SETUP;
          last_grant_d = grant_idx;
          lat_idx_d    = grant_idx;
          lat_we_d     = grant_idx ? port1.we : port0.we;
          addr_d       = grant_idx ? port1.addr : port0.addr;
          wdata_d      = grant_idx ? port1.wdata : port0.wdata;
          ce_d         = STROBE_ON;
          ub_d         = ~sel_be[1];
          lb_d         = ~sel_be[0];
          oe_d         = lat_we_d ? STROBE_OFF : STROBE_ON;
          we_d         = STROBE_OFF;
          drive_en_d   = lat_we_d;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        if (lat_we_q) begin
          we_d = STROBE_ON;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          we_d    = STROBE_OFF;
          oe_d    = STROBE_OFF;
          ack0_d  = (lat_idx_q == 1'b0);
          ack1_d  = (lat_idx_q == 1'b1);
          if (!lat_we_q) begin
            if (lat_idx_q) begin
              rdata1_d = sram_rdata;
            end else begin
              rdata0_d = sram_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        ce_d       = STROBE_OFF;
        ub_d       = STROBE_OFF;
        lb_d       = STROBE_OFF;
        drive_en_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      lat_idx_q    <= 1'b0;
      lat_we_q     <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ce_q         <= STROBE_OFF;
      oe_q         <= STROBE_OFF;
      we_q         <= STROBE_OFF;
      ub_q         <= STROBE_OFF;
      lb_q         <= STROBE_OFF;
      drive_en_q   <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_idx_q    <= lat_idx_d;
      lat_we_q     <= lat_we_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ce_q         <= ce_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      ub_q         <= ub_d;
      lb_q         <= lb_d;
      drive_en_q   <= drive_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign ADDR        = addr_q;
  assign CE          = ce_q;
  assign OE          = oe_q;
  assign WE          = we_q;
  assign UB          = ub_q;
  assign LB          = lb_q;
  assign sram_wdata  = wdata_q;
  assign drive_en    = drive_en_q;
  assign port0.ack   = ack0_q;
  assign port1.ack   = ack1_q;
  assign port0.rdata = rdata0_q;
  assign port1.rdata = rdata1_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences every SRAM cycle and shares the single off-chip SRAM between two requesters.
- Port 0 is the SLC-3 datapath (MAR/MDR memory access); port 1 is a debug/program-loader port.
- Generates the active-low CE/OE/WE/UB/LB strobes, ADDR and the data-bus drive enable with fixed wait states; the toplevel builds the tristate on Data.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
WAIT_CYCLES, 2, cycles in ACCESS state; legal range 1..15 (elaboration error otherwise)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
req0  in  1  port 0 request; held until ack0
we0  in  1  port 0: 1=write, 0=read
be0  in  2  port 0 byte enables, active high; [1]=upper, [0]=lower
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
rdata0  out  DATA_W  port 0 read data, registered
ack0  out  1  port 0 completion pulse, one cycle
req1, we1, be1, addr1, wdata1, rdata1, ack1  same as port 0, for port 1
ADDR  out  ADDR_W  SRAM address
CE  out  1  chip enable, active low
OE  out  1  output enable, active low
WE  out  1  write enable, active low
UB  out  1  upper byte enable, active low
LB  out  1  lower byte enable, active low
sram_wdata  out  DATA_W  data to drive onto Data
drive_en  out  1  1 = toplevel drives sram_wdata onto Data
sram_rdata  in  DATA_W  Data bus value as read

Behaviour:
- Reset (asynchronous, Reset=0):
  - CE, OE, WE, UB, LB = 1.
  - ADDR, sram_wdata, rdata0, rdata1 = 0.
  - drive_en, ack0, ack1 = 0.
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
- All outputs are registered.
- States: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port that is not last_grant.
  - On grant: latch we, be, addr, wdata; update last_grant; go to SETUP.
- SETUP (1 cycle):
  - ADDR = latched address; CE = 0.
  - UB = ~be[1]; LB = ~be[0].
  - Read: OE = 0. Write: OE = 1, drive_en = 1, WE stays 1 for address setup.
- ACCESS:
  - Write: WE = 0.
  - Down-counter loaded with WAIT_CYCLES-1 on entry to ACCESS.
  - Read: on the last ACCESS cycle (counter = 0), capture sram_rdata into the granted port's rdata.
- DONE (1 cycle):
  - WE = 1 and OE = 1; CE, UB, LB stay asserted.
  - drive_en stays 1 for writes, as data hold.
  - ack of the granted port = 1.
  - Next edge: CE, UB, LB, drive_en return to 1/0 and state = IDLE.
- Timing:
  - Latency: req sampled in IDLE at cycle 0 -> ack high at cycle WAIT_CYCLES+2.
  - Minimum issue period: WAIT_CYCLES+3 cycles.
- Handshake:
  - rdataN holds its value until that port's next read completes.
  - A req still high on the cycle after ack is a new request.
- Boundary conditions:
  - If req drops mid-transaction, the transaction completes and ack still pulses.
  - Input changes after grant are ignored.
  - Both ports requesting continuously: grants alternate. No port waits more than one foreign transaction.
  - be = 00 read or write: the cycle runs with UB = LB = 1, so no byte is affected; ack still pulses.
  - Reset mid-transaction: strobes go inactive immediately (not at the next clock), no ack is issued, and the in-flight write is abandoned.
  - ack0 and ack1 are never high in the same cycle.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE);
  - port index typedef (1 bit);
  - default WAIT_CYCLES constant;
  - localparams for inactive strobe level (1'b1).
- One sub-module, rr_arb2:
  - inputs: req0, req1, last_grant;
  - outputs: grant_valid, grant_idx;
  - purely combinational, instantiated by the FSM.

Test Plan:
- Read: port 0 read, addr0=20'h00031, sram_rdata=16'h1234, WAIT_CYCLES=2 -> OE low cycles 1-3, CE low cycles 1-4, ack0 at cycle 4 only, rdata0=16'h1234, WE never low.
- Write: port 1 write, addr1=20'h00005, wdata1=16'hA0A0, be1=2'b11 -> ADDR=5, WE low exactly cycles 2-3, drive_en high cycles 1-4, sram_wdata=A0A0, ack1 at cycle 4.
- Round-robin: req0 and req1 both held high from reset release -> grant order 0,1,0,1; acks alternate every 5 cycles; never simultaneous.
- Byte write: port 0 write, be0=2'b10, wdata0=16'hFF00 -> UB=0 and LB=1 during SETUP through DONE.
- Reset mid-operation: Reset=0 during the second ACCESS cycle of a write -> CE/WE/OE/UB/LB = 1 and drive_en = 0 within the same cycle, no ack; after release, a port 0 read completes normally in 4 cycles.
- Dropped request: req0 dropped in SETUP -> ack0 still pulses at cycle 4; no second transaction starts.
